ifid_ctrl: RTL and testbench

IFID_CTRL -- requirements
Module: ifid_ctrl

---
 rtl/ifid_ctrl.sv | 104 ++++++++++
 tb/tb_ifid_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ifid_ctrl.sv
// IF/ID pipeline control: PC register, IF/ID latch, stall/flush handling and hold watchdog.
// Optional total-hold counter output stall_cnt is built when IFID_STALL_CNT_EN is defined.
module ifid_ctrl #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter int          STALL_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pcdrive,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instr_in,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        idex_bubble,
  output logic        stall_err
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} stateT;

  localparam logic [2:0] HOLD_LIMIT = 3'(STALL_LIMIT);

  stateT       state, nextState;
  logic        hold;
  logic [15:0] pcNext, instrNext, ifidPcNext;
  logic        validNext;
  logic [2:0]  holdCnt, holdCntInc;

  // stall wins over pcdrive, so stall=1/pcdrive=1 is still a hold
  assign hold        = stall | ~pcdrive;
  assign idex_bubble = branch_taken | hold;
  assign holdCntInc  = (holdCnt == 3'd7) ? holdCnt : holdCnt + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= nextState;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextState  = state;
    pcNext     = pc;
    instrNext  = ifid_instr;
    ifidPcNext = ifid_pc;
    validNext  = ifid_valid;
    if (branch_taken) begin
      pcNext    = branch_target;
      instrNext = 16'h0000;
      validNext = 1'b0;
      nextState = FLUSH;
    end else if (hold) begin
      nextState = STALL;
    end else begin
      pcNext     = pc + 16'd1;
      instrNext  = instr_in;
      ifidPcNext = pc;
      validNext  = 1'b1;
      nextState  = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= PC_RESET;
      ifid_instr <= 16'h0000;
      ifid_pc    <= 16'h0000;
      ifid_valid <= 1'b0;
    end else begin
      pc         <= pcNext;
      ifid_instr <= instrNext;
      ifid_pc    <= ifidPcNext;
      ifid_valid <= validNext;
    end
  end

  // Watchdog: consecutive hold cycles; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdCnt   <= 3'd0;
      stall_err <= 1'b0;
    end else if (hold) begin
      holdCnt <= holdCntInc;
      if (holdCntInc == HOLD_LIMIT) stall_err <= 1'b1;
    end else begin
      holdCnt <= 3'd0;
    end
  end

`ifdef IFID_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= 16'h0000;
    else if (hold && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ifid_ctrl.sv
// Directed self-checking bench for ifid_ctrl: reset, stalls, flushes, watchdog, wrap and async reset.
module tb_ifid_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, pcdrive, branch_taken;
  logic [15:0] branch_target, instr_in;
  logic [15:0] pc, ifid_instr, ifid_pc;
  logic        ifid_valid, idex_bubble, stall_err;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ifid_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pcdrive(pcdrive),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr_in(instr_in),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .idex_bubble(idex_bubble), .stall_err(stall_err)
`ifdef IFID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; pcdrive = 1'b1; branch_taken = 1'b0;
    branch_target = 16'h0000; instr_in = 16'h1230;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
    checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, 16'h0000); end
    checks++; if (ifid_pc !== 16'h0000) begin errors++; $display("FAIL reset_ifid_pc got=%h exp=%h", ifid_pc, 16'h0000); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", stall_err); end
    step();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_edge_pc got=%h exp=%h", pc, 16'h0000); end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL release_pc got=%h exp=%h", pc, 16'h0001); end
    checks++; if (ifid_instr !== 16'h1230) begin errors++; $display("FAIL release_instr got=%h exp=%h", ifid_instr, 16'h1230); end
    checks++; if (ifid_pc !== 16'h0000) begin errors++; $display("FAIL release_ifid_pc got=%h exp=%h", ifid_pc, 16'h0000); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL release_valid got=%b exp=1", ifid_valid); end
  endtask

  task automatic test_fetch();
    for (int i = 1; i <= 4; i++) begin
      instr_in = 16'h1000 + 16'(i);
      step();
    end
    checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL fetch_pc got=%h exp=%h", pc, 16'h0005); end
    checks++; if (ifid_instr !== 16'h1004) begin errors++; $display("FAIL fetch_instr got=%h exp=%h", ifid_instr, 16'h1004); end
    checks++; if (ifid_pc !== 16'h0004) begin errors++; $display("FAIL fetch_ifid_pc got=%h exp=%h", ifid_pc, 16'h0004); end
  endtask

  task automatic test_single_stall();
    stall = 1'b1; pcdrive = 1'b0; instr_in = 16'hBEEF;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL stall_bubble got=%b exp=1", idex_bubble); end
    step();
    checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL stall_pc got=%h exp=%h", pc, 16'h0005); end
    checks++; if (ifid_instr !== 16'h1004) begin errors++; $display("FAIL stall_instr got=%h exp=%h", ifid_instr, 16'h1004); end
    checks++; if (ifid_pc !== 16'h0004) begin errors++; $display("FAIL stall_ifid_pc got=%h exp=%h", ifid_pc, 16'h0004); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", ifid_valid); end
    stall = 1'b0; pcdrive = 1'b1; instr_in = 16'h2005;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL run_bubble got=%b exp=0", idex_bubble); end
    step();
    checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL resume_pc got=%h exp=%h", pc, 16'h0006); end
    checks++; if (ifid_instr !== 16'h2005) begin errors++; $display("FAIL resume_instr got=%h exp=%h", ifid_instr, 16'h2005); end
    checks++; if (ifid_pc !== 16'h0005) begin errors++; $display("FAIL resume_ifid_pc got=%h exp=%h", ifid_pc, 16'h0005); end
  endtask

  task automatic test_hold_variants();
    stall = 1'b0; pcdrive = 1'b0; instr_in = 16'hDEAD;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL nodrive_bubble got=%b exp=1", idex_bubble); end
    step();
    checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL nodrive_pc got=%h exp=%h", pc, 16'h0006); end
    stall = 1'b1; pcdrive = 1'b1;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL stall_wins_bubble got=%b exp=1", idex_bubble); end
    step();
    checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL stall_wins_pc got=%h exp=%h", pc, 16'h0006); end
    stall = 1'b0; instr_in = 16'h3006;
    step();
    checks++; if (pc !== 16'h0007) begin errors++; $display("FAIL after_hold_pc got=%h exp=%h", pc, 16'h0007); end
    checks++; if (ifid_pc !== 16'h0006) begin errors++; $display("FAIL after_hold_ifid_pc got=%h exp=%h", ifid_pc, 16'h0006); end
  endtask

  task automatic test_branch_during_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040; instr_in = 16'h4444;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL branch_bubble got=%b exp=1", idex_bubble); end
    step();
    checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL branch_pc got=%h exp=%h", pc, 16'h0040); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL branch_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL branch_instr got=%h exp=%h", ifid_instr, 16'h0000); end
    stall = 1'b0; branch_taken = 1'b0; instr_in = 16'h5040;
    step();
    checks++; if (pc !== 16'h0041) begin errors++; $display("FAIL flush_pc got=%h exp=%h", pc, 16'h0041); end
    checks++; if (ifid_instr !== 16'h5040) begin errors++; $display("FAIL flush_instr got=%h exp=%h", ifid_instr, 16'h5040); end
    checks++; if (ifid_pc !== 16'h0040) begin errors++; $display("FAIL flush_ifid_pc got=%h exp=%h", ifid_pc, 16'h0040); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got=%b exp=1", ifid_valid); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL flush_err got=%b exp=0", stall_err); end
  endtask

  task automatic test_back_to_back();
    branch_taken = 1'b1; branch_target = 16'h0080;
    step();
    branch_target = 16'h0090;
    step();
    checks++; if (pc !== 16'h0090) begin errors++; $display("FAIL b2b_pc got=%h exp=%h", pc, 16'h0090); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", ifid_valid); end
    branch_taken = 1'b0; instr_in = 16'hA090;
    step();
    checks++; if (pc !== 16'h0091) begin errors++; $display("FAIL b2b_resume_pc got=%h exp=%h", pc, 16'h0091); end
    checks++; if (ifid_pc !== 16'h0090) begin errors++; $display("FAIL b2b_resume_ifid_pc got=%h exp=%h", ifid_pc, 16'h0090); end
  endtask

  task automatic test_watchdog();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL wd_early got=%b exp=0", stall_err); end
    step();
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL wd_set got=%b exp=1", stall_err); end
    checks++; if (pc !== 16'h0091) begin errors++; $display("FAIL wd_pc got=%h exp=%h", pc, 16'h0091); end
    stall = 1'b0; instr_in = 16'h6091;
    step();
    checks++; if (pc !== 16'h0092) begin errors++; $display("FAIL wd_resume_pc got=%h exp=%h", pc, 16'h0092); end
    step();
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", stall_err); end
    rst_n = 1'b0;
    #1;
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL wd_reset got=%b exp=0", stall_err); end
    #2; rst_n = 1'b1; instr_in = 16'h7000;
    step();
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL wd_rel_pc got=%h exp=%h", pc, 16'h0001); end
    checks++; if (ifid_instr !== 16'h7000) begin errors++; $display("FAIL wd_rel_instr got=%h exp=%h", ifid_instr, 16'h7000); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup_pc got=%h exp=%h", pc, 16'hFFFF); end
    branch_taken = 1'b0; instr_in = 16'h8FFF;
    step();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, 16'h0000); end
    checks++; if (ifid_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_ifid_pc got=%h exp=%h", ifid_pc, 16'hFFFF); end
    checks++; if (ifid_instr !== 16'h8FFF) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", ifid_instr, 16'h8FFF); end
  endtask

  task automatic test_async_reset();
    instr_in = 16'h0101;
    step(); step();
    stall = 1'b1;
    step();
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL ar_pre_pc got=%h exp=%h", pc, 16'h0002); end
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL ar_pc got=%h exp=%h", pc, 16'h0000); end
    checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL ar_instr got=%h exp=%h", ifid_instr, 16'h0000); end
    checks++; if (ifid_pc !== 16'h0000) begin errors++; $display("FAIL ar_ifid_pc got=%h exp=%h", ifid_pc, 16'h0000); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", ifid_valid); end
    stall = 1'b0; instr_in = 16'h9000;
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL ar_rel_pc got=%h exp=%h", pc, 16'h0001); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL ar_rel_valid got=%b exp=1", ifid_valid); end
    branch_taken = 1'b1; branch_target = 16'h0100;
    step();
    checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL arf_pre_pc got=%h exp=%h", pc, 16'h0100); end
    branch_taken = 1'b0;
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL arf_pc got=%h exp=%h", pc, 16'h0000); end
    instr_in = 16'hB000;
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL arf_rel_pc got=%h exp=%h", pc, 16'h0001); end
    checks++; if (ifid_instr !== 16'hB000) begin errors++; $display("FAIL arf_rel_instr got=%h exp=%h", ifid_instr, 16'hB000); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_single_stall();
    test_hold_variants();
    test_branch_during_stall();
    test_back_to_back();
    test_watchdog();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
